// File: rtl/avmm_s0_pkg.sv
// Shared constants and types for the s0 mailbox slave.
// Optional write wait state: MM_S0_WRITE_WAITSTATE_EN.
package avmm_s0_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int IDX_W      = ADDR_W - 2;
  localparam int RD_LATENCY = 2;

  localparam logic [IDX_W-1:0] IDX_STATUS   = 8'd254;
  localparam logic [IDX_W-1:0] IDX_DOORBELL = 8'd255;

  typedef enum logic {
    IDLE,
    WWAIT
  } state_t;

endpackage

// File: rtl/avmm_s0_rdpipe.sv
// Two-stage read response pipeline: index stage, then data stage.
// Both stages clear on reset so no stale response escapes.
module avmm_s0_rdpipe
  import avmm_s0_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_go,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [IDX_W-1:0]  cap_idx,
  input  logic [DATA_W-1:0] cap_word,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic v1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1            <= 1'b0;
      cap_idx       <= '0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      v1            <= rd_go;
      readdatavalid <= v1;
      if (rd_go) cap_idx <= rd_idx;
      // readdata holds between responses
      if (v1) readdata <= cap_word;
    end
  end

endmodule

// File: rtl/avmm_mailbox_s0.sv
// 256x32 Avalon-MM mailbox with STATUS word and doorbell interrupt.
// Optional write wait state: MM_S0_WRITE_WAITSTATE_EN.
module avmm_mailbox_s0
  import avmm_s0_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_burstcount,
  input  logic              s0_debugaccess,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  output logic              doorbell_irq
);

  logic [DATA_W-1:0] mem [256];
  logic [15:0]       wr_count;
  logic              irq;
  logic              wr_go;
  logic              rd_go;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_word;
  logic              unused;

  assign idx    = s0_address[ADDR_W-1:2];
  assign unused = ^{s0_address[1:0], s0_burstcount,
                    s0_debugaccess};

`ifdef MM_S0_WRITE_WAITSTATE_EN
  state_t state;

  assign s0_waitrequest = !reset_reset && state == IDLE
                          && s0_write;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (s0_write) state <= WWAIT;
        WWAIT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign s0_waitrequest = 1'b0;
`endif

  // a simultaneous read is dropped in favour of the write
  assign wr_go = !reset_reset && s0_write && !s0_waitrequest;
  assign rd_go = !reset_reset && s0_read && !s0_write
                 && !s0_waitrequest;

  always_ff @(posedge clk_clk) begin
    if (wr_go && idx != IDX_STATUS) begin
      for (int b = 0; b < BE_W; b++) begin
        if (s0_byteenable[b])
          mem[idx][8*b +: 8] <= s0_writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_count <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_go) wr_count <= wr_count + 16'd1;
      if (rd_go && idx == IDX_DOORBELL) irq <= 1'b0;
      // set wins over a same-cycle clear
      if (wr_go && idx == IDX_DOORBELL) irq <= 1'b1;
    end
  end

  assign cap_word = (cap_idx == IDX_STATUS)
                    ? {irq, 15'b0, wr_count}
                    : mem[cap_idx];

  assign doorbell_irq = irq;

  avmm_s0_rdpipe u_rdpipe (
    .clk           (clk_clk),
    .reset         (reset_reset),
    .rd_go         (rd_go),
    .rd_idx        (idx),
    .cap_idx       (cap_idx),
    .cap_word      (cap_word),
    .readdata      (s0_readdata),
    .readdatavalid (s0_readdatavalid)
  );

endmodule

// File: tb/tb_avmm_mailbox_s0.sv
// Scoreboard bench for avmm_mailbox_s0 against a word-array model.
// Covers both builds (MM_S0_WRITE_WAITSTATE_EN on/off).
module tb_avmm_mailbox_s0;
  import avmm_s0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        bc;
  logic        dbg;
  logic        waitreq;
  logic [31:0] rdata;
  logic        rdv;
  logic        irq;

  avmm_mailbox_s0 dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .s0_address       (addr),
    .s0_read          (rd),
    .s0_write         (wr),
    .s0_writedata     (wdata),
    .s0_byteenable    (be),
    .s0_burstcount    (bc),
    .s0_debugaccess   (dbg),
    .s0_waitrequest   (waitreq),
    .s0_readdata      (rdata),
    .s0_readdatavalid (rdv),
    .doorbell_irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  logic [31:0] m_mem [256];
  logic        m_irq;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: every response must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rdv === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %h expected none", rdata);
      end else begin
        e = q.pop_front();
        check("rd_data", rdata, e.data);
        check("rd_latency", cyc, e.due);
      end
    end
  end

  function automatic logic [31:0] status_word();
    logic [15:0] c;
    c = m_cnt[15:0];
    return {m_irq, 15'b0, c};
  endfunction

  task automatic model_apply(input logic r, input logic w,
                             input logic [9:0] a,
                             input logic [31:0] d,
                             input logic [3:0] b);
    int i;
    i = int'(a[9:2]);
    if (w) begin
      if (i != 254)
        for (int k = 0; k < 4; k++)
          if (b[k]) m_mem[i][8*k +: 8] = d[8*k +: 8];
      if (i == 255) m_irq = 1'b1;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (r) begin
      q.push_back('{(i == 254) ? status_word() : m_mem[i],
                    cyc + 2});
      if (i == 255) m_irq = 1'b0;
    end
  endtask

  // one bus request, held until accepted
  task automatic bus(input logic r, input logic w,
                     input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; be = b;
    bc = 1'($urandom); dbg = 1'($urandom);
    while (!acc) begin
      #1;
      check("irq", irq, m_irq);
`ifdef MM_S0_WRITE_WAITSTATE_EN
      check("waitreq", waitreq, (w && n == 0) ? 1 : 0);
`else
      check("waitreq", waitreq, 0);
`endif
      acc = !waitreq;
      if (acc) begin
        if (r || w) model_apply(r, w, a, d, b);
      end else begin
        n++;
        if (n > 4) begin
          tests++;
          fails++;
          $display("FAIL wait_timeout: got stall expected accept");
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) bus(0, 0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    q.delete();
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_irq = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] v;
    int          op;
    rst = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0;
    be = 0; bc = 0; dbg = 0;
    m_irq = 1'b0;
    m_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_rdv", rdv, 0);
    check("rst_irq", irq, 0);
    check("rst_waitreq", waitreq, 0);
    rst = 1'b0;

    bus(1, 0, 10'h3F8, 0, 0);
    // fill every word so later reads are defined
    for (int i = 0; i < 256; i++)
      bus(0, 1, 10'(i * 4), $urandom, 4'hF);

    bus(0, 1, 10'h010, 32'hDEADBEEF, 4'hF);
    bus(1, 0, 10'h010, 0, 0);
    bus(0, 1, 10'h020, 32'h11223344, 4'hF);
    bus(0, 1, 10'h020, 32'hAABBCCDD, 4'h5);
    bus(1, 0, 10'h020, 0, 0);
    idle(3);
    check("be_merge", m_mem[8], 32'h11BB33DD);

    bus(1, 0, 10'h000, 0, 0);
    bus(1, 0, 10'h004, 0, 0);
    bus(1, 0, 10'h008, 0, 0);
    bus(1, 0, 10'h004, 0, 0);
    bus(0, 1, 10'h004, 32'h0BADF00D, 4'hF);
    bus(1, 0, 10'h004, 0, 0);

    bus(0, 1, 10'h3FC, 32'hCAFE0001, 4'h0);
    bus(1, 0, 10'h3F8, 0, 0);
    bus(1, 0, 10'h3FC, 0, 0);
    idle(2);
    bus(1, 0, 10'h3F8, 0, 0);

    do_reset(2);
    bus(0, 1, 10'h100, $urandom, 4'hF);
    bus(0, 1, 10'h3F8, $urandom, 4'hF);
    bus(0, 1, 10'h104, $urandom, 4'h3);
    bus(1, 0, 10'h3F8, 0, 0);
    idle(3);

    for (int t = 0; t < 3000; t++) begin
      op = int'($urandom_range(0, 3));
      a = 10'($urandom);
      if ($urandom_range(0, 3) == 0) a[9:3] = 7'h7F;
      bus(op[0], op[1], a, $urandom, 4'($urandom));
    end
    idle(3);

    bus(1, 0, 10'h010, 0, 0);
    bus(1, 0, 10'h014, 0, 0);
    do_reset(2);
    idle(4);

`ifdef MM_S0_WRITE_WAITSTATE_EN
    v = m_mem[16];
    @(negedge clk);
    wr = 1; rd = 0; addr = 10'h040; wdata = ~v; be = 4'hF;
    #1;
    check("ws_stall", waitreq, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ws_rst_wait", waitreq, 0);
    @(negedge clk);
    rst = 1'b0; wr = 0;
    m_irq = 1'b0;
    m_cnt = 0;
    #1;
    check("ws_after_rst", waitreq, 0);
    bus(1, 0, 10'h040, 0, 0);
    bus(1, 0, 10'h3F8, 0, 0);
`else
    while (m_cnt != 65535)
      bus(0, 1, 10'($urandom_range(0, 253) * 4), $urandom, 4'($urandom));
    bus(1, 0, 10'h3F8, 0, 0);
    bus(0, 1, 10'h3F8, $urandom, 4'hF);
    bus(1, 0, 10'h3F8, 0, 0);
`endif

    idle(6);
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
